// File: rtl/alu_pkg.sv
// Shared ALUOp encodings, MIPS R-type funct constants and issue FSM states
// used by the ALU issue stage and its funct decoder.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SRL = 3'd4,
        ALU_SRA = 3'd5
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_funct_dec.sv
// Maps a MIPS R-type funct field to an ALUOp, flags unsupported functs and
// marks the shift ops that take their operands from rt/shamt.
module alu_funct_dec
    import alu_pkg::*;
(
    input  logic [5:0] funct,
    output alu_op_e    op,
    output logic       illegal,
    output logic       shift_sel
);

    always_comb begin
        op        = ALU_ADD;
        illegal   = 1'b0;
        shift_sel = 1'b0;
        case (funct)
            FUNCT_ADDU: op = ALU_ADD;
            FUNCT_SUBU: op = ALU_SUB;
            FUNCT_AND:  op = ALU_AND;
            FUNCT_OR:   op = ALU_OR;
            FUNCT_SRL: begin
                op        = ALU_SRL;
                shift_sel = 1'b1;
            end
            FUNCT_SRA: begin
                op        = ALU_SRA;
                shift_sel = 1'b1;
            end
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Issue stage for one R-type ALU op: registers operands toward an external
// combinational ALU, captures its result and hands it back as a response.
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_funct,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    input  logic [4:0]  req_shamt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [15:0] op_count,
    output state_e      dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both 1; valid never depends on ready, and rsp_* holds while unready.

    state_e      state_q, state_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] op_count_q, op_count_d;

    alu_op_e dec_op;
    logic    dec_illegal;
    logic    dec_shift;

    alu_funct_dec u_dec (
        .funct     (req_funct),
        .op        (dec_op),
        .illegal   (dec_illegal),
        .shift_sel (dec_shift)
    );

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        op_count_d = op_count_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (dec_illegal) begin
                        // ALU operands stay as they were; only the response reports the error.
                        state_d    = ST_RESP;
                        rsp_data_d = 32'd0;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_d   = ST_EXEC;
                        rsp_err_d = 1'b0;
                        alu_a_d   = dec_shift ? req_rt : req_rs;
                        alu_b_d   = dec_shift ? {27'd0, req_shamt} : req_rt;
                        alu_op_d  = dec_op;
                    end
                end
            end
            ST_EXEC: begin
                rsp_data_d = alu_c;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                    if (!rsp_err_q) begin
                        op_count_d = op_count_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            alu_a_q    <= 32'd0;
            alu_b_q    <= 32'd0;
            alu_op_q   <= 3'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
            op_count_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            op_count_q <= op_count_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign op_count  = op_count_q;
    assign dbg_state = state_q;

endmodule
